// File: rtl/rc_pkg.sv
// Shared definitions for the route-computation stage: direction codes,
// flit type codes, flit field positions and the route-lock state type.
package rc_pkg;

    // One-hot output port codes; all-zero is local, all-ones means no route
    localparam logic [3:0] DIR_W     = 4'b1000;
    localparam logic [3:0] DIR_N     = 4'b0100;
    localparam logic [3:0] DIR_E     = 4'b0010;
    localparam logic [3:0] DIR_S     = 4'b0001;
    localparam logic [3:0] DIR_LOCAL = 4'b0000;
    localparam logic [3:0] DIR_NONE  = 4'b1111;

    localparam logic [1:0] TYPE_HEAD   = 2'b01;
    localparam logic [1:0] TYPE_BODY   = 2'b00;
    localparam logic [1:0] TYPE_TAIL   = 2'b10;
    localparam logic [1:0] TYPE_SINGLE = 2'b11;

    // Destination is {dst_y, dst_x} in bits [35:32]; flit type in [1:0]
    localparam int DST_HI  = 35;
    localparam int DST_LO  = 32;
    localparam int TYPE_HI = 1;
    localparam int TYPE_LO = 0;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } rc_state_e;

endpackage

// File: rtl/rc_adaptive_if.sv
// Flit handshake bundle: data/valid travel from master to slave,
// ready travels back from slave to master.
interface rc_adaptive_if #(
    parameter int DATASIZE = 40
);
    logic [DATASIZE-1:0] data;
    logic                valid;
    logic                ready;

    modport master (output data, output valid, input  ready);
    modport slave  (input  data, input  valid, output ready);
endinterface

// File: rtl/rc_route_sel.sv
// Combinational minimal-route selector for a 2D mesh node.
// With RC_ADAPTIVE_EN defined, a packet that can make progress in both X
// and Y takes the port with lower downstream pressure (ties go to X).
// Without it, routing is deterministic XY and the pressure inputs are unused.
module rc_route_sel
    import rc_pkg::*;
#(
    parameter int WIDTH  = 3,
    parameter int MESH_X = 3,
    parameter int MESH_Y = 3,
    parameter int NODE_X = 2,
    parameter int NODE_Y = 2
) (
    input  logic [3:0]     dst,
    input  logic [WIDTH:0] n_pressure,
    input  logic [WIDTH:0] e_pressure,
    input  logic [WIDTH:0] s_pressure,
    input  logic [WIDTH:0] w_pressure,
    output logic [3:0]     dir,
    output logic           err
);

    // Mesh dimensions need one extra bit since they may equal 4
    localparam logic [2:0] MX = 3'(MESH_X);
    localparam logic [2:0] MY = 3'(MESH_Y);
    localparam logic [1:0] NX = 2'(NODE_X);
    localparam logic [1:0] NY = 2'(NODE_Y);

    logic [1:0] dst_x;
    logic [1:0] dst_y;
    logic       x_lo;
    logic       y_lo;
    logic       x_eq;
    logic       y_eq;
    logic [3:0] x_dir;
    logic [3:0] y_dir;
    logic       pick_x;

    assign dst_x = dst[1:0];
    assign dst_y = dst[3:2];
    assign x_lo  = (dst_x < NX);
    assign y_lo  = (dst_y < NY);
    assign x_eq  = (dst_x == NX);
    assign y_eq  = (dst_y == NY);
    assign x_dir = x_lo ? DIR_W : DIR_E;
    assign y_dir = y_lo ? DIR_N : DIR_S;

`ifdef RC_ADAPTIVE_EN
    logic [WIDTH:0] x_press;
    logic [WIDTH:0] y_press;
    assign x_press = x_lo ? w_pressure : e_pressure;
    assign y_press = y_lo ? n_pressure : s_pressure;
    assign pick_x  = (x_press <= y_press);
`else
    logic unused_pressure;
    assign unused_pressure = ^{n_pressure, e_pressure, s_pressure, w_pressure};
    assign pick_x          = 1'b1;
`endif

    // Out-of-mesh addresses win over everything; otherwise pick a productive port
    always_comb begin
        err = ({1'b0, dst_x} >= MX) || ({1'b0, dst_y} >= MY);
        dir = DIR_NONE;
        if (err) begin
            dir = DIR_NONE;
        end else if (x_eq && y_eq) begin
            dir = DIR_LOCAL;
        end else if (y_eq) begin
            dir = x_dir;
        end else if (x_eq) begin
            dir = y_dir;
        end else begin
            dir = pick_x ? x_dir : y_dir;
        end
    end

endmodule

// File: rtl/rc_adaptive.sv
// Route-computation stage for one router input port: decodes the flit,
// picks an output port, locks that port for the rest of a wormhole packet
// and presents the flit through a one-entry registered valid/ready stage.
// Build option: RC_ADAPTIVE_EN enables pressure-based X/Y selection.
module rc_adaptive
    import rc_pkg::*;
#(
    parameter int DATASIZE = 40,
    parameter int WIDTH    = 3,
    parameter int MESH_X   = 3,
    parameter int MESH_Y   = 3,
    parameter int NODE_X   = 2,
    parameter int NODE_Y   = 2
) (
    input  logic                rc_clk,
    input  logic                rst,
    rc_adaptive_if.slave        in_if,
    rc_adaptive_if.master       out_if,
    output logic [3:0]          direction_out,
    output logic                err,
    input  logic [WIDTH:0]      N_pressure_in,
    input  logic [WIDTH:0]      E_pressure_in,
    input  logic [WIDTH:0]      S_pressure_in,
    input  logic [WIDTH:0]      W_pressure_in
);

    rc_state_e           state_q, state_d;
    logic [3:0]          route_q, route_d;
    logic [DATASIZE-1:0] data_q, data_d;
    logic                valid_q, valid_d;
    logic [3:0]          dir_q, dir_d;
    logic                err_q, err_d;

    logic                ready;
    logic                accept;
    logic [1:0]          ftype;
    logic [3:0]          sel_dir;
    logic                sel_err;

    rc_route_sel #(
        .WIDTH  (WIDTH),
        .MESH_X (MESH_X),
        .MESH_Y (MESH_Y),
        .NODE_X (NODE_X),
        .NODE_Y (NODE_Y)
    ) u_route_sel (
        .dst        (in_if.data[DST_HI:DST_LO]),
        .n_pressure (N_pressure_in),
        .e_pressure (E_pressure_in),
        .s_pressure (S_pressure_in),
        .w_pressure (W_pressure_in),
        .dir        (sel_dir),
        .err        (sel_err)
    );

    // Ready depends only on registered state and downstream ready
    assign ready         = !valid_q || out_if.ready;
    assign accept        = in_if.valid && ready;
    assign ftype         = in_if.data[TYPE_HI:TYPE_LO];
    assign in_if.ready   = ready;
    assign out_if.data   = data_q;
    assign out_if.valid  = valid_q;
    assign direction_out = dir_q;
    assign err           = err_q;

    // Next-state: route lock FSM plus the output stage load/drain/hold
    always_comb begin
        state_d = state_q;
        route_d = route_q;
        data_d  = data_q;
        valid_d = valid_q;
        dir_d   = dir_q;
        err_d   = 1'b0;
        if (accept) begin
            data_d  = in_if.data;
            valid_d = 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (ftype == TYPE_HEAD) begin
                        dir_d   = sel_dir;
                        route_d = sel_dir;
                        err_d   = sel_err;
                        state_d = LOCKED;
                    end else if (ftype == TYPE_SINGLE) begin
                        dir_d   = sel_dir;
                        err_d   = sel_err;
                    end else begin
                        // Body or tail with no open packet has nowhere to go
                        dir_d   = DIR_NONE;
                        err_d   = 1'b1;
                    end
                end
                LOCKED: begin
                    if (ftype == TYPE_BODY) begin
                        dir_d   = route_q;
                    end else if (ftype == TYPE_TAIL) begin
                        dir_d   = route_q;
                        state_d = IDLE;
                    end else begin
                        // A new head/single abandons the open packet
                        dir_d   = sel_dir;
                        route_d = sel_dir;
                        err_d   = 1'b1;
                        state_d = (ftype == TYPE_HEAD) ? LOCKED : IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end else if (out_if.ready) begin
            valid_d = 1'b0;
            dir_d   = DIR_NONE;
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge rc_clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            route_q <= DIR_NONE;
            data_q  <= '0;
            valid_q <= 1'b0;
            dir_q   <= DIR_NONE;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            route_q <= route_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            dir_q   <= dir_d;
            err_q   <= err_d;
        end
    end

endmodule
